// File: rtl/gps_wb_arb_pkg.sv
// Shared types and sizing helpers for the GPS Wishbone arbiter.
package gps_wb_arb_pkg;

   localparam int unsigned DefNumMasters = 2;
   localparam int unsigned DefAddrWidth  = 32;
   localparam int unsigned DefDataWidth  = 32;
   localparam int unsigned DefTimeout    = 256;
   localparam int unsigned TcountW       = 8;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDrain
   } arb_state_e;

   function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gps_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i, wrapping, as a one-hot grant.
module rr_arbiter
   import gps_wb_arb_pkg::*;
#(
   parameter int unsigned NumReq = 2
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [idx_w(NumReq)-1:0]  last_i,
   output logic [NumReq-1:0]         gnt_o
);

   localparam int unsigned IdxW = idx_w(NumReq);

   logic            found;
   logic [IdxW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned off = 1; off <= NumReq; off++) begin
         idx = IdxW'((32'(last_i) + off) % NumReq);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gps_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the GPS slave port, with a bus-timeout watchdog.
module gps_wb_arbiter
   import gps_wb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = DefNumMasters,
   parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
   parameter int unsigned DATA_WIDTH  = DefDataWidth,
   parameter int unsigned TIMEOUT     = DefTimeout
) (
   input  logic                                wb_clk_i,
   input  logic                                wb_rst_i,
   input  logic [NUM_MASTERS-1:0]              m_cyc_i,
   input  logic [NUM_MASTERS-1:0]              m_stb_i,
   input  logic [NUM_MASTERS-1:0]              m_we_i,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
   output logic [DATA_WIDTH-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]              m_ack_o,
   output logic [NUM_MASTERS-1:0]              m_err_o,
   output logic                                s_cyc_o,
   output logic                                s_stb_o,
   output logic                                s_we_o,
   output logic [DATA_WIDTH/8-1:0]             s_sel_o,
   output logic [ADDR_WIDTH-1:0]               s_adr_o,
   output logic [DATA_WIDTH-1:0]               s_dat_o,
   input  logic [DATA_WIDTH-1:0]               s_dat_i,
   input  logic                                s_ack_i,
   input  logic                                s_err_i,
   output logic [NUM_MASTERS-1:0]              grant_o,
   output logic [TcountW-1:0]                  timeout_count_o
);

   localparam int unsigned SelW = DATA_WIDTH / 8;
   localparam int unsigned IdxW = idx_w(NUM_MASTERS);
   localparam int unsigned CntW = timeout_cnt_w(TIMEOUT);

   arb_state_e             state_q;
   logic [NUM_MASTERS-1:0] grant_q;
   logic [IdxW-1:0]        owner_q;
   logic [IdxW-1:0]        last_q;
   logic [CntW-1:0]        wd_q;
   logic [TcountW-1:0]     tcount_q;

   logic [NUM_MASTERS-1:0] pick;
   logic [IdxW-1:0]        pick_idx;
   logic                   own_cyc, own_stb, own_we;
   logic [SelW-1:0]        own_sel;
   logic [ADDR_WIDTH-1:0]  own_adr;
   logic [DATA_WIDTH-1:0]  own_dat;
   logic                   busy;
   logic                   expire;

   rr_arbiter #(
      .NumReq (NUM_MASTERS)
   ) u_rr (
      .req_i  (m_cyc_i),
      .last_i (last_q),
      .gnt_o  (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (pick[i]) pick_idx = IdxW'(i);
      end
   end

   always_comb begin
      own_cyc = m_cyc_i[owner_q];
      own_stb = m_stb_i[owner_q];
      own_we  = m_we_i[owner_q];
      own_sel = m_sel_i[int'(owner_q)*SelW +: SelW];
      own_adr = m_adr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
      own_dat = m_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
   end

   // Reset aborts a transfer in the very cycle it is asserted.
   assign busy   = (state_q == StBusy) && !wb_rst_i;
   assign expire = busy && own_cyc && own_stb && !s_ack_i && !s_err_i &&
                   (wd_q == CntW'(TIMEOUT - 1));

   always_comb begin
      s_cyc_o = busy && own_cyc && !expire;
      s_stb_o = busy && own_stb && !expire;
      s_we_o  = busy && own_we;
      s_sel_o = busy ? own_sel : '0;
      s_adr_o = busy ? own_adr : '0;
      s_dat_o = busy ? own_dat : '0;
      m_dat_o = busy ? s_dat_i : '0;
      m_ack_o = '0;
      m_err_o = '0;
      if (busy) begin
         m_ack_o[owner_q] = s_ack_i;
         m_err_o[owner_q] = s_err_i | expire;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         owner_q  <= '0;
         last_q   <= IdxW'(NUM_MASTERS - 1);
         wd_q     <= '0;
         tcount_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               wd_q <= '0;
               if (|m_cyc_i) begin
                  grant_q <= pick;
                  owner_q <= pick_idx;
                  state_q <= StBusy;
               end
            end
            StBusy: begin
               if (!own_cyc) begin
                  state_q <= StIdle;
                  grant_q <= '0;
                  last_q  <= owner_q;
                  wd_q    <= '0;
               end else if (expire) begin
                  state_q <= StDrain;
                  wd_q    <= '0;
                  if (tcount_q != '1) tcount_q <= tcount_q + 1'b1;
               end else if (own_stb && !s_ack_i && !s_err_i) begin
                  wd_q <= wd_q + 1'b1;
               end else begin
                  wd_q <= '0;
               end
            end
            StDrain: begin
               // Owner keeps the grant until it lets go of cyc; late slave responses are dropped.
               if (!own_cyc) begin
                  state_q <= StIdle;
                  grant_q <= '0;
                  last_q  <= owner_q;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant_o         = grant_q;
   assign timeout_count_o = tcount_q;

endmodule

// File: tb/tb_gps_wb_arbiter.sv
// Directed bench for gps_wb_arbiter: per-master drivers, a simple slave, and a per-cycle model check.
module tb_gps_wb_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
   logic [N*SW-1:0] m_sel_i;
   logic [N*AW-1:0] m_adr_i;
   logic [N*DW-1:0] m_dat_i;
   logic [DW-1:0]   m_dat_o;
   logic [N-1:0]    m_ack_o, m_err_o;
   logic            s_cyc_o, s_stb_o, s_we_o;
   logic [SW-1:0]   s_sel_o;
   logic [AW-1:0]   s_adr_o;
   logic [DW-1:0]   s_dat_o, s_dat_i;
   logic            s_ack_i, s_err_i;
   logic [N-1:0]    grant_o;
   logic [7:0]      timeout_count_o;

   gps_wb_arbiter #(
      .NUM_MASTERS (N),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .TIMEOUT     (TO)
   ) dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .m_cyc_i         (m_cyc_i),
      .m_stb_i         (m_stb_i),
      .m_we_i          (m_we_i),
      .m_sel_i         (m_sel_i),
      .m_adr_i         (m_adr_i),
      .m_dat_i         (m_dat_i),
      .m_dat_o         (m_dat_o),
      .m_ack_o         (m_ack_o),
      .m_err_o         (m_err_o),
      .s_cyc_o         (s_cyc_o),
      .s_stb_o         (s_stb_o),
      .s_we_o          (s_we_o),
      .s_sel_o         (s_sel_o),
      .s_adr_o         (s_adr_o),
      .s_dat_o         (s_dat_o),
      .s_dat_i         (s_dat_i),
      .s_ack_i         (s_ack_i),
      .s_err_i         (s_err_i),
      .grant_o         (grant_o),
      .timeout_count_o (timeout_count_o)
   );

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   // Slave: responds slv_lat cycles into an uninterrupted owner strobe.
   logic slv_en = 1'b0, slv_err = 1'b0, force_ack = 1'b0;
   int   slv_lat = 0;
   int   slv_cnt = 0;
   logic owner_stb, hit;
   assign owner_stb = |(grant_o & m_cyc_i & m_stb_i);
   assign hit       = slv_en && owner_stb && (slv_cnt == slv_lat);
   assign s_ack_i   = force_ack | (hit & ~slv_err);
   assign s_err_i   = hit & slv_err;
   assign s_dat_i   = 32'hDA7A_0000 ^ 32'(cyc_n);
   always @(posedge clk) slv_cnt <= (owner_stb && !s_ack_i && !s_err_i) ? slv_cnt + 1 : 0;

   int   job_req[N];
   int   cfg_beats[N];
   logic cfg_we[N];
   int   cfg_hold[N];

   for (genvar g = 0; g < N; g++) begin : drv
      logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
      logic [SW-1:0] sel = '0;
      logic [AW-1:0] adr = '0;
      logic [DW-1:0] dat = '0;
      int            done = 0;
      int            acks, t;
      logic          got_ack, got_err, abort;
      assign m_cyc_i[g]            = cyc;
      assign m_stb_i[g]            = stb;
      assign m_we_i[g]             = we;
      assign m_sel_i[g*SW +: SW]   = sel;
      assign m_adr_i[g*AW +: AW]   = adr;
      assign m_dat_i[g*DW +: DW]   = dat;
      initial begin
         forever begin
            @(posedge clk); #1;
            if (done < job_req[g]) begin
               acks = 0;
               t    = 0;
               cyc  = 1'b1;
               stb  = 1'b1;
               we   = cfg_we[g];
               sel  = (g == 0) ? 4'hF : 4'h3;
               adr  = AW'(32'h100 * (g + 1));
               dat  = DW'(32'hC0DE_0000 + 32'(g * 16));
               while (1) begin
                  @(negedge clk);
                  got_ack = m_ack_o[g];
                  got_err = m_err_o[g];
                  abort   = rst;
                  @(posedge clk); #1;
                  t++;
                  if (abort) break;
                  if (got_ack) begin
                     acks++;
                     if (acks >= cfg_beats[g]) break;
                     adr = adr + 4;
                     dat = dat + 1;
                  end
                  if (got_err) begin
                     stb = 1'b0;
                     repeat (cfg_hold[g]) begin @(posedge clk); #1; end
                     break;
                  end
                  if (t > 500) break;
               end
               cyc  = 1'b0;
               stb  = 1'b0;
               we   = 1'b0;
               done = done + 1;
            end
         end
      end
   end

   // Monitor: grant order log and per-master response bookkeeping.
   int         glog[$];
   int         ack_cnt[N], err_cnt[N], rise_cyc[N], ack_cyc[N], err_cyc[N];
   logic [N-1:0] prev_cyc = '0, prev_gnt = '0;
   always @(negedge clk) begin
      for (int g = 0; g < N; g++) begin
         if (m_cyc_i[g] && !prev_cyc[g]) rise_cyc[g] = cyc_n;
         if (m_ack_o[g]) begin ack_cnt[g]++; ack_cyc[g] = cyc_n; end
         if (m_err_o[g]) begin err_cnt[g]++; err_cyc[g] = cyc_n; end
      end
      if (grant_o != '0 && grant_o != prev_gnt) begin
         for (int g = 0; g < N; g++) if (grant_o[g]) glog.push_back(g);
      end
      prev_cyc = m_cyc_i;
      prev_gnt = grant_o;
   end

   // Model: owner index (-1 idle), drain flag, strobed-wait count, last owner, terminations.
   int mo_own = -1, mo_wait = 0, mo_last = N - 1, mo_tc = 0;
   bit mo_drain = 1'b0;
   always @(negedge clk) begin : cmp
      logic [N-1:0]  e_gnt, e_ack, e_err;
      logic          e_cyc, e_stb, e_we, expired, busy;
      logic [SW-1:0] e_sel;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat, e_mdat;
      int            o, pk;
      e_gnt = '0; e_ack = '0; e_err = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; expired = 1'b0;
      e_sel = '0; e_adr = '0; e_dat = '0; e_mdat = '0;
      if (mo_own >= 0) e_gnt[mo_own] = 1'b1;
      busy = !rst && mo_own >= 0 && !mo_drain;
      if (busy) begin
         o       = mo_own;
         expired = m_cyc_i[o] && m_stb_i[o] && !s_ack_i && !s_err_i && (mo_wait == TO - 1);
         e_cyc   = m_cyc_i[o] && !expired;
         e_stb   = m_stb_i[o] && !expired;
         e_we    = m_we_i[o];
         e_sel   = m_sel_i[o*SW +: SW];
         e_adr   = m_adr_i[o*AW +: AW];
         e_dat   = m_dat_i[o*DW +: DW];
         e_mdat  = s_dat_i;
         e_ack[o] = s_ack_i;
         e_err[o] = s_err_i | expired;
      end
      check("grant", 64'(grant_o), 64'(e_gnt));
      check("tcount", 64'(timeout_count_o), 64'(mo_tc));
      check("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
      check("s_stb", 64'(s_stb_o), 64'(e_stb));
      check("m_ack", 64'(m_ack_o), 64'(e_ack));
      check("m_err", 64'(m_err_o), 64'(e_err));
      if (busy || mo_own < 0) begin
         check("s_we", 64'(s_we_o), 64'(e_we));
         check("s_sel", 64'(s_sel_o), 64'(e_sel));
         check("s_adr", 64'(s_adr_o), 64'(e_adr));
         check("s_dat", 64'(s_dat_o), 64'(e_dat));
         check("m_dat", 64'(m_dat_o), 64'(e_mdat));
      end
      if (rst) begin
         mo_own = -1; mo_drain = 1'b0; mo_wait = 0; mo_last = N - 1; mo_tc = 0;
      end else if (mo_own < 0) begin
         pk = -1;
         for (int k = 1; k <= N; k++) begin
            if (pk < 0 && m_cyc_i[(mo_last + k) % N]) pk = (mo_last + k) % N;
         end
         if (pk >= 0) begin mo_own = pk; mo_wait = 0; end
      end else if (!m_cyc_i[mo_own]) begin
         mo_last = mo_own; mo_own = -1; mo_drain = 1'b0;
      end else if (!mo_drain) begin
         if (expired) begin
            mo_drain = 1'b1;
            mo_tc    = (mo_tc < 255) ? mo_tc + 1 : 255;
         end else if (m_stb_i[mo_own] && !s_ack_i && !s_err_i) begin
            mo_wait++;
         end else begin
            mo_wait = 0;
         end
      end
   end

   function automatic bit all_done();
      return (drv[0].done == job_req[0]) && (drv[1].done == job_req[1]);
   endfunction

   task automatic wait_done(input string nm, input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(all_done() && grant_o == '0) && n < lim);
      check(nm, 64'(all_done() && grant_o == '0), 64'(1));
   endtask

   task automatic wait_grant(input string nm, input logic [N-1:0] g, input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (grant_o != g && n < lim);
      check(nm, 64'(grant_o), 64'(g));
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   int base, a0, a1, e0, e1;
   int alt_exp[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

   initial begin
      for (int i = 0; i < N; i++) begin
         job_req[i] = 0; cfg_beats[i] = 1; cfg_we[i] = 1'b0; cfg_hold[i] = 0;
         ack_cnt[i] = 0; err_cnt[i] = 0; rise_cyc[i] = 0; ack_cyc[i] = 0; err_cyc[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single read by master 0, slave responds on the 4th strobed cycle.
      slv_en = 1'b1; slv_lat = 3;
      a0 = ack_cnt[0];
      @(negedge clk); job_req[0]++;
      wait_done("t1_done", 100);
      check("t1_acks", 64'(ack_cnt[0] - a0), 64'(1));
      check("t1_latency", 64'(ack_cyc[0] - rise_cyc[0]), 64'(4));

      // Strict alternation from reset with both masters always requesting.
      pulse_reset();
      @(posedge clk); #1 slv_lat = 1;
      base = glog.size();
      @(negedge clk); job_req[0] += 5; job_req[1] += 5;
      wait_done("alt_done", 400);
      check("alt_count", 64'(glog.size() - base), 64'(10));
      for (int i = 0; i < 10; i++) begin
         if (base + i < glog.size()) check("alt_order", 64'(glog[base + i]), 64'(alt_exp[i]));
      end

      // Slave never answers: watchdog error, then a late ack in drain is swallowed.
      @(posedge clk); #1 slv_en = 1'b0;
      e0 = err_cnt[0]; a0 = ack_cnt[0];
      @(negedge clk); cfg_hold[0] = 3; job_req[0]++;
      for (int n = 0; n < 100 && err_cnt[0] == e0; n++) @(negedge clk);
      check("to_err_seen", 64'(err_cnt[0] - e0), 64'(1));
      @(posedge clk); #1 force_ack = 1'b1;
      @(posedge clk); #1 force_ack = 1'b0;
      wait_done("to_done", 100);
      cfg_hold[0] = 0;
      check("to_err_cycle", 64'(err_cyc[0] - rise_cyc[0]), 64'(16));
      check("to_count", 64'(timeout_count_o), 64'(1));
      check("to_err_once", 64'(err_cnt[0] - e0), 64'(1));
      check("to_no_ack", 64'(ack_cnt[0] - a0), 64'(0));

      // Ack exactly on the expiry cycle wins.
      @(posedge clk); #1 slv_en = 1'b1; slv_lat = 15;
      a0 = ack_cnt[0]; e0 = err_cnt[0];
      @(negedge clk); job_req[0]++;
      wait_done("edge_done", 100);
      check("edge_ack", 64'(ack_cnt[0] - a0), 64'(1));
      check("edge_no_err", 64'(err_cnt[0] - e0), 64'(0));
      check("edge_latency", 64'(ack_cyc[0] - rise_cyc[0]), 64'(16));
      check("edge_count", 64'(timeout_count_o), 64'(1));

      // Reset while master 1 holds the bus mid-write.
      @(posedge clk); #1 slv_en = 1'b0;
      a1 = ack_cnt[1]; e1 = err_cnt[1];
      @(negedge clk); cfg_we[1] = 1'b1; job_req[1]++;
      wait_grant("rst_owner", 2'b10, 50);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rst_grant", 64'(grant_o), 64'(0));
      check("rst_count", 64'(timeout_count_o), 64'(0));
      check("rst_scyc", 64'(s_cyc_o), 64'(0));
      check("rst_no_resp", 64'((ack_cnt[1] - a1) + (err_cnt[1] - e1)), 64'(0));
      wait_done("rst_drop", 50);
      @(posedge clk); #1 slv_en = 1'b1; slv_lat = 2; cfg_we[1] = 1'b0;
      base = glog.size();
      @(negedge clk); job_req[0]++; job_req[1]++;
      wait_done("rst_cont_done", 100);
      check("rst_first", 64'(glog[base]), 64'(0));
      check("rst_second", 64'(glog[base + 1]), 64'(1));

      // Master 1 streams 4 writes in one cyc; master 0 waits past TIMEOUT untouched.
      @(posedge clk); #1 slv_lat = 5;
      a0 = ack_cnt[0]; a1 = ack_cnt[1]; e0 = err_cnt[0]; e1 = err_cnt[1];
      base = glog.size();
      @(negedge clk); cfg_beats[1] = 4; cfg_we[1] = 1'b1; job_req[1]++;
      wait_grant("pipe_owner", 2'b10, 50);
      job_req[0]++;
      wait_done("pipe_done", 300);
      check("pipe_m1_acks", 64'(ack_cnt[1] - a1), 64'(4));
      check("pipe_m0_acks", 64'(ack_cnt[0] - a0), 64'(1));
      check("pipe_no_err", 64'((err_cnt[0] - e0) + (err_cnt[1] - e1)), 64'(0));
      check("pipe_order", 64'(glog[base + 1]), 64'(0));
      check("pipe_count", 64'(timeout_count_o), 64'(0));

      // Slave error is routed to the owner only and is not a watchdog event.
      @(posedge clk); #1 slv_err = 1'b1; slv_lat = 2;
      e0 = err_cnt[0]; e1 = err_cnt[1];
      @(negedge clk); cfg_beats[1] = 1; cfg_we[1] = 1'b0; job_req[1]++;
      wait_done("serr_done", 100);
      check("serr_m1", 64'(err_cnt[1] - e1), 64'(1));
      check("serr_m0", 64'(err_cnt[0] - e0), 64'(0));
      check("serr_count", 64'(timeout_count_o), 64'(0));
      @(posedge clk); #1 slv_err = 1'b0;

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
